tpram_bypass_clr: RTL and testbench

Parametrised two-port RAM with one write port and one read port, both on a single clock. It adds byte-enable writes, a selectable 1- or 2-cycle read latency with a valid strobe, and same-address write-to-read bypass. A post-reset clear sweep zeroes the array before the first access. It sits where the plain two-port RAM is used today and is the default buffer for mesh router input queues and tile scratchpads.

---
 rtl/tpram_bypass_clr.sv | 130 +++++++++++++
 tb/tb_tpram_bypass_clr.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/tpram_bypass_clr.sv
// rtl/tpram_bypass_clr.sv - two-port RAM with byte strobes, 1/2-cycle read latency, write bypass and post-reset clear
module tpram_bypass_clr #(
    parameter int    DATA_WIDTH     = 32,
    parameter int    BYTE_WIDTH     = 8,
    parameter int    DEPTH          = 1024,
    parameter int    READ_LATENCY   = 1,
    parameter int    BYPASS         = 1,
    parameter int    CLEAR_ON_RESET = 1,
    parameter string RAM_STYLE_VAL  = "block",
    localparam int   NBYTES         = DATA_WIDTH / BYTE_WIDTH,
    localparam int   AW             = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  wen,
    input  logic [NBYTES-1:0]     wstrb,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  ren,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rvalid,
    output logic                  ready
);

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    (* ram_style = RAM_STYLE_VAL *) logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [0:0]            state;
    logic [AW-1:0]         clr_addr;
    logic                  clr_en;
    logic                  wr_in_range;
    logic                  rd_in_range;
    logic                  wr_acc;
    logic                  rd_acc;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  s1_valid;
    logic [DATA_WIDTH-1:0] s1_data;

    assign ready       = (state == ST_RUN);
    assign clr_en      = !reset && (state == ST_CLEAR);
    assign wr_in_range = ({{(32-AW){1'b0}}, waddr} < 32'(DEPTH));
    assign rd_in_range = ({{(32-AW){1'b0}}, raddr} < 32'(DEPTH));
    // Accesses are only honoured once the sweep is done and never while reset is held.
    assign wr_acc      = wen && ready && !reset && wr_in_range;
    assign rd_acc      = ren && ready && !reset;

    // Sweep state: CLEAR walks every address once, then hands over to RUN.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
            clr_addr <= '0;
        end else if (state == ST_CLEAR) begin
            clr_addr <= clr_addr + AW'(1);
            if (clr_addr == AW'(DEPTH - 1)) begin
                state <= ST_RUN;
            end
        end
    end

    // Array write: clear sweep has the port to itself; otherwise per-lane strobed writes.
    always_ff @(posedge clock) begin
        if (clr_en) begin
            mem[clr_addr] <= '0;
        end else if (wr_acc) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (wstrb[i]) begin
                    mem[waddr][i*BYTE_WIDTH +: BYTE_WIDTH] <= wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    // Read word: out-of-range reads give zero; with bypass, strobed lanes of a colliding write win.
    always_comb begin
        rd_word = '0;
        if (rd_in_range) begin
            rd_word = mem[raddr];
        end
        if ((BYPASS != 0) && wr_acc && (waddr == raddr)) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (wstrb[i]) begin
                    rd_word[i*BYTE_WIDTH +: BYTE_WIDTH] = wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    // Stage 1 captures the read on the accept edge so later writes cannot disturb it.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= rd_acc;
            if (rd_acc) begin
                s1_data <= rd_word;
            end
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic                  s2_valid;
            logic [DATA_WIDTH-1:0] s2_data;

            // Stage 2 only reloads behind a valid stage 1, so rdata holds between reads.
            always_ff @(posedge clock) begin
                if (reset) begin
                    s2_valid <= 1'b0;
                    s2_data  <= '0;
                end else begin
                    s2_valid <= s1_valid;
                    if (s1_valid) begin
                        s2_data <= s1_data;
                    end
                end
            end

            assign rdata  = s2_data;
            assign rvalid = s2_valid;
        end else begin : g_lat1
            assign rdata  = s1_data;
            assign rvalid = s1_valid;
        end
    endgenerate

endmodule

// File: tb/tb_tpram_bypass_clr.sv
// tb/tb_tpram_bypass_clr.sv - self-checking bench for tpram_bypass_clr across latency/bypass variants
module tb_tpram_bypass_clr;

    localparam int DEPTH = 12;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        wen   = 1'b0;
    logic [3:0]  wstrb = 4'h0;
    logic [3:0]  waddr = 4'h0;
    logic [31:0] wdata = 32'h0;
    logic        ren   = 1'b0;
    logic [3:0]  raddr = 4'h0;

    logic [31:0] rdata_a  [4];
    logic        rvalid_a [4];
    logic        ready_a  [4];

    int n_checks = 0;
    int n_errors = 0;

    // Instance g: READ_LATENCY = 1 + g[1], BYPASS = g[0].
    for (genvar g = 0; g < 4; g++) begin : g_dut
        tpram_bypass_clr #(
            .DATA_WIDTH(32), .BYTE_WIDTH(8), .DEPTH(DEPTH),
            .READ_LATENCY(1 + g / 2), .BYPASS(g % 2), .CLEAR_ON_RESET(1),
            .RAM_STYLE_VAL("block")
        ) dut (
            .clock(clock), .reset(reset),
            .wen(wen), .wstrb(wstrb), .waddr(waddr), .wdata(wdata),
            .ren(ren), .raddr(raddr),
            .rdata(rdata_a[g]), .rvalid(rvalid_a[g]), .ready(ready_a[g])
        );
    end

    always #5 clock = ~clock;

    // Reference model state
    logic [31:0] m_mem [DEPTH];
    int          m_clr   = 0;
    bit          m_ready = 1'b0;
    bit          p1_v = 1'b0, p2_v = 1'b0;
    logic [31:0] p1_d [2];
    logic [31:0] p2_d [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: model the edge from the inputs now applied, then compare all instances.
    task automatic cycle();
        logic        wacc, racc;
        logic [31:0] old_w, byp_w;
        wacc  = wen && m_ready && !reset && (waddr < DEPTH);
        racc  = ren && m_ready && !reset;
        old_w = (raddr < DEPTH) ? m_mem[raddr] : 32'h0;
        byp_w = old_w;
        if (wacc && waddr == raddr)
            for (int i = 0; i < 4; i++)
                if (wstrb[i]) byp_w[i*8 +: 8] = wdata[i*8 +: 8];
        @(posedge clock);
        if (reset) begin
            m_ready = 1'b0; m_clr = 0;
            p1_v = 1'b0; p2_v = 1'b0;
            p1_d[0] = 0; p1_d[1] = 0; p2_d[0] = 0; p2_d[1] = 0;
        end else begin
            if (!m_ready) begin
                m_mem[m_clr] = 32'h0;
                if (m_clr == DEPTH - 1) m_ready = 1'b1;
                m_clr++;
            end
            if (wacc)
                for (int i = 0; i < 4; i++)
                    if (wstrb[i]) m_mem[waddr][i*8 +: 8] = wdata[i*8 +: 8];
            if (p1_v) begin p2_d[0] = p1_d[0]; p2_d[1] = p1_d[1]; end
            p2_v = p1_v;
            p1_v = racc;
            if (racc) begin p1_d[0] = old_w; p1_d[1] = byp_w; end
        end
        #1;
        for (int g = 0; g < 4; g++) begin
            check($sformatf("ready[%0d]", g), ready_a[g], m_ready);
            check($sformatf("rvalid[%0d]", g), rvalid_a[g], (g >= 2) ? p2_v : p1_v);
            check($sformatf("rdata[%0d]", g), rdata_a[g], (g >= 2) ? p2_d[g % 2] : p1_d[g % 2]);
        end
    endtask

    // Directed access with hand-computed results for read-first (e0) and bypass (e1).
    task automatic access(input logic we, input logic [3:0] strb, input logic [3:0] wa,
                          input logic [31:0] wd, input logic re, input logic [3:0] ra,
                          input logic [31:0] e0, input logic [31:0] e1, input string tag);
        wen = we; wstrb = strb; waddr = wa; wdata = wd; ren = re; raddr = ra;
        cycle();
        wen = 1'b0; ren = 1'b0;
        if (re) begin
            check({tag, "_rv_l1"}, rvalid_a[0] & rvalid_a[1], 1);
            check({tag, "_l1_bp0"}, rdata_a[0], e0);
            check({tag, "_l1_bp1"}, rdata_a[1], e1);
        end
        cycle();
        if (re) begin
            check({tag, "_rv_l2"}, rvalid_a[2] & rvalid_a[3], 1);
            check({tag, "_l2_bp0"}, rdata_a[2], e0);
            check({tag, "_l2_bp1"}, rdata_a[3], e1);
        end
    endtask

    task automatic wait_ready(input string tag);
        int k;
        k = 0;
        while (k < 40 && !ready_a[0]) begin
            cycle();
            k++;
        end
        check(tag, k, DEPTH);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
        p1_d[0] = 0; p1_d[1] = 0; p2_d[0] = 0; p2_d[1] = 0;

        // Reset with requests active: nothing may happen.
        wen = 1'b1; wstrb = 4'hF; waddr = 4'd2; wdata = 32'hDEADBEEF; ren = 1'b1; raddr = 4'd2;
        cycle();
        check("rst_ready", ready_a[0], 0);
        check("rst_rvalid", rvalid_a[0], 0);
        check("rst_rdata", rdata_a[0], 32'h0);
        cycle();
        reset = 1'b0;
        wait_ready("clear_len_first");

        // Fill some words, then reset in RUN; the sweep must zero them.
        for (int a = 0; a < DEPTH; a++)
            access(1'b1, 4'hF, 4'(a), 32'h5A5A0000 + a, 1'b0, 4'd0, 0, 0, "fill");
        reset = 1'b1; cycle(); reset = 1'b0;
        // Requests held during the sweep, restart at clear cycle 7.
        wen = 1'b1; ren = 1'b1;
        for (int k = 0; k < 7; k++) cycle();
        check("clear_mid_ready", ready_a[0], 0);
        reset = 1'b1; cycle(); cycle(); reset = 1'b0;
        wait_ready("clear_len_restart");
        wen = 1'b0; ren = 1'b0;
        for (int a = 0; a < DEPTH; a++)
            access(1'b0, 4'h0, 4'd0, 0, 1'b1, 4'(a), 32'h0, 32'h0, "clr_rd");

        // Byte strobes
        access(1'b1, 4'hF, 4'd3, 32'hAABBCCDD, 1'b0, 4'd0, 0, 0, "strb_w1");
        access(1'b1, 4'b0101, 4'd3, 32'h11223344, 1'b0, 4'd0, 0, 0, "strb_w2");
        access(1'b0, 4'h0, 4'd0, 0, 1'b1, 4'd3, 32'hAA22CC44, 32'hAA22CC44, "strb_rd");
        access(1'b1, 4'h0, 4'd3, 32'h0, 1'b1, 4'd3, 32'hAA22CC44, 32'hAA22CC44, "strb_zero");

        // Bypass collision
        access(1'b1, 4'hF, 4'd5, 32'hFFFFFFFF, 1'b0, 4'd0, 0, 0, "byp_init");
        access(1'b1, 4'b0011, 4'd5, 32'h0, 1'b1, 4'd5, 32'hFFFFFFFF, 32'hFFFF0000, "byp");
        access(1'b0, 4'h0, 4'd0, 0, 1'b1, 4'd5, 32'hFFFF0000, 32'hFFFF0000, "byp_after");
        access(1'b1, 4'hF, 4'd6, 32'h12345678, 1'b1, 4'd5, 32'hFFFF0000, 32'hFFFF0000, "diff_addr");

        // Back-to-back reads with a write hitting an in-flight address
        for (int a = 0; a < 4; a++)
            access(1'b1, 4'hF, 4'(8 + a), a + 1, 1'b0, 4'd0, 0, 0, "tp_fill");
        for (int i = 0; i < 6; i++) begin
            ren = (i < 4); raddr = 4'(8 + i);
            wen = (i == 2); wstrb = 4'hF; waddr = 4'd9; wdata = 32'd9;
            cycle();
            if (i >= 1 && i <= 4) begin
                check($sformatf("tp_rv_%0d", i), rvalid_a[2] & rvalid_a[3], 1);
                check($sformatf("tp_bp0_%0d", i), rdata_a[2], i);
                check($sformatf("tp_bp1_%0d", i), rdata_a[3], i);
            end
        end
        wen = 1'b0; ren = 1'b0;
        access(1'b0, 4'h0, 4'd0, 0, 1'b1, 4'd9, 32'd9, 32'd9, "tp_new");

        // Out-of-range addresses
        access(1'b1, 4'hF, 4'd13, 32'h77777777, 1'b0, 4'd0, 0, 0, "oor_w");
        access(1'b0, 4'h0, 4'd0, 0, 1'b1, 4'd13, 32'h0, 32'h0, "oor_rd");
        access(1'b0, 4'h0, 4'd0, 0, 1'b1, 4'd5, 32'hFFFF0000, 32'hFFFF0000, "oor_alias");

        // Random soak against the model
        for (int i = 0; i < 1500; i++) begin
            wen   = 1'($urandom_range(0, 1));
            wstrb = 4'($urandom);
            waddr = 4'($urandom_range(0, 15));
            wdata = $urandom;
            ren   = 1'($urandom_range(0, 1));
            raddr = ($urandom_range(0, 2) == 0) ? waddr : 4'($urandom_range(0, 15));
            cycle();
        end
        wen = 1'b0; ren = 1'b0;
        cycle(); cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
